mcmem_ctrl: RTL and testbench

Parametrised single-clock memory controller for the multicycle computer. It replaces the separate-memclk synchronous RAM with an internal word-addressed array behind a req/ready handshake. It supports configurable data width, depth and wait states, plus byte-enabled writes. It sits between the multicycle CPU's memory port (adr/tom/fromm/wmem) and the on-chip storage.

---
 rtl/mcmem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mcmem_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mcmem_ctrl.sv
// mcmem_ctrl: single-clock, word-addressed on-chip memory controller for the
// multicycle CPU memory port. Each access walks IDLE -> WAIT (optional) ->
// ACCESS -> DONE and completes with a one-cycle ready pulse. Writes are
// byte-enabled. The upper byte-address bits above the word index are ignored,
// so addresses alias modulo the array depth.
//
// Ports:
//   clk    in   rising-edge clock
//   clr    in   asynchronous active-high reset
//   req    in   access request, sampled only in IDLE
//   we     in   1 = write, 0 = read
//   be     in   byte enables (writes only)
//   adr    in   byte address
//   tom    in   write data
//   fromm  out  read data / post-write word, held until the next ACCESS edge
//   ready  out  one-cycle completion pulse
//   busy   out  transaction in flight
//   err    out  misaligned-access flag (0 unless MCMEM_ALIGN_CHECK_EN)
//
// Build option: define MCMEM_ALIGN_CHECK_EN to flag misaligned accesses.
// A flagged access keeps normal timing, does not write the array, returns
// fromm=0 and raises err together with ready.
//
// state  | meaning
// IDLE   | waiting for req; captures the request on acceptance
// WAIT   | WAIT_STATES stall cycles, counter runs 0..WAIT_STATES-1
// ACCESS | array read or byte-merged write at the closing edge
// DONE   | ready pulse, back to IDLE

module mcmem_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      req,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]     adr,
  input  logic [DATA_WIDTH-1:0]     tom,
  output logic [DATA_WIDTH-1:0]     fromm,
  output logic                      ready,
  output logic                      busy,
  output logic                      err
);

  localparam int BW    = DATA_WIDTH / 8;
  localparam int AL    = (BW > 1) ? $clog2(BW) : 0;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t                  state, state_n;
  logic [3:0]              wait_cnt;
  logic                    we_q;
  logic [BW-1:0]           be_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   tom_q;
  logic [DATA_WIDTH-1:0]   fromm_q;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    mis_q;
  logic                    accept;
  logic                    unused_adr;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign accept = (state == IDLE) && req;

  // Only the index bits (and, with the check enabled, the low bits) matter.
  assign unused_adr = ^adr;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (wait_cnt == WS_LAST) state_n = ACCESS;
      ACCESS:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      be_q     <= '0;
      idx_q    <= '0;
      tom_q    <= '0;
      fromm_q  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= ((state == WAIT) && (state_n == WAIT)) ? wait_cnt + 4'd1 : 4'd0;
      if (accept) begin
        we_q  <= we;
        be_q  <= be;
        idx_q <= adr[DEPTH_LOG2+AL-1:AL];
        tom_q <= tom;
      end
      if (state == ACCESS) begin
        if (mis_q)
          fromm_q <= '0;
        else
          fromm_q <= we_q ? merged : rd_word;
      end
    end
  end

`ifdef MCMEM_ALIGN_CHECK_EN
  logic mis_in;
  logic err_q;

  if (AL > 0) begin : g_mis
    assign mis_in = |adr[AL-1:0];
  end else begin : g_nomis
    assign mis_in = 1'b0;
  end

  // err_q is set by the ACCESS edge and cleared by the DONE edge, so it is
  // high exactly in the DONE cycle alongside ready.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) mis_q <= mis_in;
      err_q <= (state == ACCESS) && mis_q;
    end
  end

  assign err = err_q;
`else
  assign mis_q = 1'b0;
  assign err   = 1'b0;
`endif

  assign rd_word = mem[idx_q];

  always_comb begin
    merged = rd_word;
    for (int k = 0; k < BW; k++) begin
      if (be_q[k]) merged[8*k +: 8] = tom_q[8*k +: 8];
    end
  end

  // Storage has no reset; a reset before the ACCESS edge forces IDLE, so no
  // write can follow an aborted request.
  always_ff @(posedge clk) begin
    if ((state == ACCESS) && we_q && !mis_q) mem[idx_q] <= merged;
  end

  assign fromm = fromm_q;
  assign ready = (state == DONE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mcmem_ctrl.sv
module tb_mcmem_ctrl;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        clr;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] adr;
  logic [31:0] tom;

  logic [31:0] fromm, fromm0, fromm3;
  logic        ready, ready0, ready3;
  logic        busy, busy0, busy3;
  logic        err, err0, err3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mcmem_ctrl u_dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .be(be), .adr(adr), .tom(tom),
    .fromm(fromm), .ready(ready), .busy(busy), .err(err)
  );

  mcmem_ctrl #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .clr(clr), .req(req), .we(we), .be(be), .adr(adr), .tom(tom),
    .fromm(fromm0), .ready(ready0), .busy(busy0), .err(err0)
  );

  mcmem_ctrl #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .clr(clr), .req(req), .we(we), .be(be), .adr(adr), .tom(tom),
    .fromm(fromm3), .ready(ready3), .busy(busy3), .err(err3)
  );

  // One transaction on u_dut: expected result queued at request time, popped
  // and compared on ready. Inputs are scrambled while busy.
  task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d,
                        input logic exp_e, input string name);
    exp_t e;
    int   cyc;
    @(negedge clk);
    req = 1'b1; we = w; be = b; adr = a; tom = d;
    e.data = exp_d;
    e.err  = exp_e;
    exp_q.push_back(e);
    @(negedge clk);
    req = 1'b0; we = ~w; be = ~b; adr = $urandom; tom = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got %b want 1", name, busy);
    end
    cyc = 1;
    while (ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != WS + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, WS + 2);
    end
    e = exp_q.pop_front();
    checks++;
    if (fromm !== e.data || err !== e.err) begin
      errors++;
      $display("FAIL %s data: got %h err %b want %h err %b", name, fromm, err, e.data, e.err);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || fromm !== e.data) begin
      errors++;
      $display("FAIL %s hold: got ready %b busy %b err %b fromm %h want 0 0 0 %h",
               name, ready, busy, err, fromm, e.data);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; adr = '0; tom = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (fromm !== 32'h0 || ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: got fromm %h ready %b busy %b err %b want 0 0 0 0",
               fromm, ready, busy, err);
    end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy %b ready %b want 0 0", busy, ready);
    end
  endtask

  task automatic test_basic();
    access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "write_10");
    access(1'b0, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "read_10");
  endtask

  task automatic test_byte_merge();
    access(1'b1, 4'b0101, 32'h10, 32'h11223344, 32'hDE22BE44, 1'b0, "merge_wr");
    access(1'b0, 4'hF,    32'h10, 32'h0,        32'hDE22BE44, 1'b0, "merge_rd");
    access(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'hDE22BE44, 1'b0, "be0_wr");
    access(1'b0, 4'b0000, 32'h10, 32'h0,        32'hDE22BE44, 1'b0, "be0_rd");
  endtask

  task automatic test_alias();
    access(1'b1, 4'hF, 32'h0000_0004, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, "alias_wr");
    access(1'b0, 4'hF, 32'h0000_1004, 32'h0,        32'hA5A5A5A5, 1'b0, "alias_rd");
  endtask

  task automatic test_back_to_back();
    int p1[$], p0[$], p3[$];
    repeat (10) @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'hF; adr = 32'h10; tom = '0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        p1.push_back(c);
        checks++;
        if (fromm !== 32'hDE22BE44) begin
          errors++;
          $display("FAIL b2b_data: got %h want de22be44", fromm);
        end
      end
      if (ready0 === 1'b1) p0.push_back(c);
      if (ready3 === 1'b1) p3.push_back(c);
    end
    req = 1'b0;
    checks++;
    if (p1.size() < 3 || p1[1] - p1[0] != 4 || p1[2] - p1[1] != 4) begin
      errors++;
      $display("FAIL b2b_ws1: got %0d pulses want spacing 4", p1.size());
    end
    checks++;
    if (p0.size() < 3 || p0[1] - p0[0] != 3 || p0[2] - p0[1] != 3) begin
      errors++;
      $display("FAIL b2b_ws0: got %0d pulses want spacing 3", p0.size());
    end
    checks++;
    if (p3.size() < 3 || p3[1] - p3[0] != 6 || p3[2] - p3[1] != 6) begin
      errors++;
      $display("FAIL b2b_ws3: got %0d pulses want spacing 6", p3.size());
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int pulses;
    access(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, "pre_wr_20");
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; adr = 32'h20; tom = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    #1 clr = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || fromm !== 32'h0) begin
      errors++;
      $display("FAIL midreset: got ready %b busy %b fromm %h want 0 0 0", ready, busy, fromm);
    end
    @(negedge clk);
    clr = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midreset_ready: got %0d pulses want 0", pulses);
    end
    access(1'b0, 4'hF, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "midreset_rd");
  endtask

  task automatic test_align();
`ifdef MCMEM_ALIGN_CHECK_EN
    access(1'b1, 4'hF, 32'h22, 32'h55555555, 32'h0,        1'b1, "align_wr");
    access(1'b0, 4'hF, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, "align_rd");
`else
    access(1'b1, 4'hF, 32'h22, 32'h77777777, 32'h77777777, 1'b0, "align_wr");
    access(1'b0, 4'hF, 32'h20, 32'h0,        32'h77777777, 1'b0, "align_rd");
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_merge();
    test_alias();
    test_back_to_back();
    test_mid_reset();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
